// File: rtl/adder_pipe_nbits.sv
// Pipelined WIDTH-bit adder/subtractor resolving SEG bits per stage.
// Each stage adds the lowest unresolved operand segment plus the carry
// from the previous stage. The remaining upper operand bits shift down
// with the beat, and the resolved sum segments accumulate from the top.
// The whole pipe advances together whenever the output is empty or is
// being consumed, so bubbles move along with the data.
module adder_pipe_nbits #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int STAGES = WIDTH / SEG;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        // IW: operand bits still unresolved entering this stage.
        // SW: result bits known after this stage.
        localparam int IW = WIDTH - gi * SEG;
        localparam int SW = (gi + 1) * SEG;

        logic          valid_in;
        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          c_in;
        logic [SW-1:0] s_next;
        logic [SEG:0]  seg_sum;

        logic          valid_reg;
        logic          c_reg;
        logic [SW-1:0] s_reg;

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                       + {{SEG{1'b0}}, c_in};

        if (gi == 0) begin : g_head
            // Subtraction is a + ~b + 1; the borrow-in inverts the carry-in.
            assign valid_in = in_valid;
            assign a_in     = a;
            assign b_in     = b ^ {WIDTH{sub}};
            assign c_in     = ci ^ sub;
            assign s_next   = seg_sum[SEG-1:0];
        end else begin : g_link
            assign valid_in = gen_stage[gi-1].valid_reg;
            assign a_in     = gen_stage[gi-1].g_fwd.a_reg;
            assign b_in     = gen_stage[gi-1].g_fwd.b_reg;
            assign c_in     = gen_stage[gi-1].c_reg;
            assign s_next   = {seg_sum[SEG-1:0], gen_stage[gi-1].s_reg};
        end

        // Stage valid bit, partial result and segment carry.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                c_reg     <= 1'b0;
                s_reg     <= '0;
            end else if (advance) begin
                valid_reg <= valid_in;
                c_reg     <= seg_sum[SEG];
                s_reg     <= s_next;
            end
        end

        if (gi < STAGES - 1) begin : g_fwd
            logic [IW-SEG-1:0] a_reg;
            logic [IW-SEG-1:0] b_reg;

            // Carry the not-yet-added operand bits to the next stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (advance) begin
                    a_reg <= a_in[IW-1:SEG];
                    b_reg <= b_in[IW-1:SEG];
                end
            end
        end else begin : g_tail
            logic cm;
            logic ov_reg;

            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
            assign cm = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1];

            // Signed overflow is the carry into the MSB differing from the carry out.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ov_reg <= 1'b0;
                end else if (advance) begin
                    ov_reg <= cm ^ seg_sum[SEG];
                end
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].valid_reg;
    assign s         = gen_stage[STAGES-1].s_reg;
    assign co        = gen_stage[STAGES-1].c_reg;
    assign ov        = gen_stage[STAGES-1].g_tail.ov_reg;

endmodule

// File: tb/tb_adder_pipe_nbits.sv
// Scoreboard bench for adder_pipe_nbits (16/4 main instance, 8/8 degenerate).
module tb_adder_pipe_nbits;
    localparam int ST = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] s;
    logic        co;
    logic        ov;

    logic        d8_in_valid = 1'b0;
    logic        d8_in_ready;
    logic [7:0]  d8_a = '0;
    logic [7:0]  d8_b = '0;
    logic        d8_out_valid;
    logic [7:0]  d8_s;
    logic        d8_co;
    logic        d8_ov;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [ST-1:0] mv = '0;

    always #5 clk = ~clk;

    adder_pipe_nbits #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .ov(ov)
    );

    adder_pipe_nbits #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .ci(1'b0), .sub(1'b0), .out_valid(d8_out_valid),
        .out_ready(1'b1), .s(d8_s), .co(d8_co), .ov(d8_ov)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic cc, input logic su);
        logic [15:0] be;
        logic [16:0] f;
        exp_t r;
        be = bb ^ {16{su}};
        f = {1'b0, aa} + {1'b0, be} + {16'd0, cc ^ su};
        r.s = f[15:0];
        r.co = f[16];
        r.ov = (aa[15] == be[15]) && (f[15] != aa[15]);
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check just after, wait a cycle.
    task automatic step(input logic iv, input logic [15:0] aa, input logic [15:0] bb,
                        input logic cc, input logic su, input logic ordy, output logic acc);
        logic adv;
        exp_t e;
        in_valid = iv; a = aa; b = bb; ci = cc; sub = su; out_ready = ordy;
        #1;
        adv = !mv[ST-1] || ordy;
        check("out_valid", {31'd0, out_valid}, {31'd0, mv[ST-1]});
        check("in_ready", {31'd0, in_ready}, {31'd0, adv});
        if (out_valid && ordy) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("pop s=%h co=%b ov=%b (exp s=%h co=%b ov=%b)", s, co, ov, e.s, e.co, e.ov);
                check("s", {16'd0, s}, {16'd0, e.s});
                check("co", {31'd0, co}, {31'd0, e.co});
                check("ov", {31'd0, ov}, {31'd0, e.ov});
            end
        end
        acc = adv && iv;
        if (adv) begin
            mv = {mv[ST-2:0], iv};
            if (iv) sb_q.push_back(model(aa, bb, cc, su));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && (sb_q.size() != 0 || mv != '0); i++)
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; d8_in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mv = '0;
        sb_q.delete();
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_co_ov", {30'd0, co, ov}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int idx;
        logic [15:0] ra, rb;
        logic rc, rs;
        @(negedge clk);
        do_reset();

        // Directed vectors, single beats with full latency.
        step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, acc); drain();
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, acc);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, acc);
        drain();

        // Back-pressure: 8 beats, out_ready low for cycles 5..7.
        idx = 0;
        for (int cyc = 0; cyc < 30 && idx < 8; cyc++) begin
            step(1'b1, 16'h1000 * idx[15:0] + 16'h0F0F, 16'h0123 + idx[15:0], idx[0], 1'b0,
                 !(cyc >= 5 && cyc <= 7), acc);
            if (acc) idx++;
        end
        check("bp_all_sent", idx, 32'd8);
        drain();

        // Reset with three beats in flight, then one fresh beat.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'hAAAA + i[15:0], 16'h1111, 1'b0, 1'b0, 1'b1, acc);
        do_reset();
        step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc);
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            step(1'($urandom_range(0, 3) != 0), ra, rb, rc, rs, 1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        // Degenerate single-stage instance: latency 1.
        d8_in_valid = 1'b1; d8_a = 8'hF0; d8_b = 8'h20;
        #1;
        check("d8_in_ready", {31'd0, d8_in_ready}, 32'd1);
        @(negedge clk);
        d8_in_valid = 1'b0;
        #1;
        check("d8_out_valid", {31'd0, d8_out_valid}, 32'd1);
        check("d8_s", {24'd0, d8_s}, 32'h10);
        check("d8_co_ov", {30'd0, d8_co, d8_ov}, 32'b10);
        $display("d8 beat s=%h co=%b ov=%b", d8_s, d8_co, d8_ov);
        @(negedge clk);
        #1;
        check("d8_out_valid_clear", {31'd0, d8_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_pipe_nbits.md
# adder_pipe_nbits

Parametrised, pipelined N-bit adder/subtractor with carry/borrow-in, carry-out and signed-overflow flags, and a valid/ready handshake on both sides. The operand is split into SEG-bit segments, with one segment resolved per pipeline stage. This gives full throughput at widths where a single-cycle ripple adder misses timing. It is the streaming, width-generic successor to the fixed 4-bit combinational adder, and it feeds datapath blocks that need back-pressured arithmetic.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- SEG, 4, bits resolved per stage; must divide WIDTH exactly.
- STAGES (localparam), WIDTH/SEG, pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  sum or difference.
- co  out  1  carry out of the MSB (raw; in subtract mode 1 = no borrow).
- ov  out  1  two's-complement signed overflow.

## Operation
- Effective operands: b_eff = b XOR {WIDTH{sub}}; c_eff = ci XOR sub.
  - sub=0: result = a + b + ci.
  - sub=1: result = a − b − ci.
- Stage k (k = 0..STAGES−1) adds segment k of a and b_eff plus the carry registered by stage k−1 (stage 0 uses c_eff). It registers:
  - the SEG-bit partial sum,
  - its carry-out,
  - for the last stage only, the carry into the MSB.
- Upper operand segments travel down the pipeline with the data; lower result segments are carried forward. Each stage holds a valid bit.
- On the final stage:
  - s = concatenation of all partial sums.
  - co = carry out of bit WIDTH−1.
  - ov = (carry into bit WIDTH−1) XOR co.
- Stall rule: advance = !out_valid || out_ready.
  - The whole pipeline shifts only when advance=1; otherwise every stage holds its contents.
  - in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - An empty stage (valid=0) still shifts, so bubbles propagate and no filler beats are inserted.
- Beats are never reordered, dropped or duplicated.
- No state machine beyond the per-stage valid bits; the pipeline is a linear shift structure.

## Timing
- Reset (rst_n=0 at a rising edge):
  - all stage valid bits, out_valid, s, co and ov clear to 0;
  - in_ready = 1 in the first cycle after reset.
- A reset in mid-operation discards every in-flight beat. out_valid is 0 on the next cycle, and no stale result appears afterwards.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1 and is consumed at edge t+STAGES. In other words, it takes STAGES cycles with no stall.
- Throughput: one beat per cycle while out_ready=1.
- Each cycle with out_valid=1 and out_ready=0 adds exactly one cycle of latency to every in-flight beat.
- s, co and ov stay stable while out_valid=1 and out_ready=0.
- A simultaneous output pop and input push in one cycle is legal; occupancy is unchanged.
- SEG=WIDTH degenerates to a single registered stage with latency 1.
- in_ready is combinational from out_ready (a single gate level); in_valid, a, b, ci and sub are sampled only on accept.

## Test plan
- WIDTH=16, SEG=4: a=0x0001, b=0x0002, ci=0, sub=0 → after 4 cycles s=0x0003, co=0, ov=0.
- Carry chain across all segments: a=0xFFFF, b=0x0001, ci=0 → s=0x0000, co=1, ov=0. Same operands with ci=1 → s=0x0001, co=1.
- Overflow and subtract:
  - a=0x7FFF, b=0x0001 add → s=0x8000, co=0, ov=1.
  - a=0x8000, b=0x0001, sub=1 → s=0x7FFF, co=1, ov=1.
  - a=0x0005, b=0x0007, sub=1 → s=0xFFFE, co=0, ov=0.
- Back-pressure: stream 8 back-to-back beats with out_ready held low for 3 cycles mid-stream → in_ready=0 in exactly those cycles, all 8 results arrive in order, and none are lost or duplicated.
- Reset mid-stream: rst_n=0 for one cycle with 3 beats in flight → out_valid=0 on the next cycle, no old result ever emerges, and a new beat then completes with latency 4.
- Degenerate config WIDTH=8, SEG=8: a=0xF0, b=0x20 → after 1 cycle s=0x10, co=1, ov=0.
